// File: rtl/mul_share_pkg.sv
// mul_share_pkg: shared state encoding and default constants for the multiplier-sharing scheduler
package mul_share_pkg;
    localparam int NUM_REQ_DEF     = 4;
    localparam int W_DEF           = 8;
    localparam int TIMEOUT_CYC_DEF = 32;
    localparam int PW_DEF          = 2 * W_DEF;
    localparam int GRANT_IW        = 3;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotate-priority pick of the first pending request at or after rr_ptr
module rr_arbiter
    import mul_share_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int IW = GRANT_IW
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_req
);
    // Scan from the farthest offset back toward rr_ptr so the nearest pending request wins
    always_comb begin
        grant_idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(rr_ptr) + k) % N]) grant_idx = IW'((int'(rr_ptr) + k) % N);
    end
    assign any_req = |req;
    assign grant   = any_req ? {{(N-1){1'b0}}, 1'b1} << grant_idx : '0;
endmodule

// File: rtl/mul_share_sched.sv
// mul_share_sched: round-robin scheduler sharing one sequential multiplier between requesters
module mul_share_sched
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int W           = W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*W-1:0] a_bus,
    input  logic [NUM_REQ*W-1:0] b_bus,
    output logic [NUM_REQ-1:0]   ack,
    output logic [2*W-1:0]       result,
    output logic                 err,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 mul_start,
    output logic [W-1:0]         mul_a,
    output logic [W-1:0]         mul_b,
    input  logic [2*W-1:0]       mul_dout,
    input  logic                 mul_done
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_t             state;
    logic [2:0]         rr_ptr;
    logic [2:0]         gidx;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] gnt_q;
    logic               any_req;
    logic [CW-1:0]      cnt;

    rr_arbiter #(.N(NUM_REQ), .IW(3)) u_arb (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .grant     (gnt),
        .grant_idx (gidx),
        .any_req   (any_req)
    );

    // Operation sequencer; cnt==0 marks the first WAIT cycle, where a done held over from the previous operation is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            ack       <= '0;
            err       <= 1'b0;
            result    <= '0;
            busy      <= 1'b0;
            grant_id  <= '0;
            gnt_q     <= '0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            cnt       <= '0;
        end else begin
            ack       <= '0;
            err       <= 1'b0;
            mul_start <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
                    grant_id  <= gidx;
                    gnt_q     <= gnt;
                    mul_a     <= a_bus[int'(gidx)*W +: W];
                    mul_b     <= b_bus[int'(gidx)*W +: W];
                    mul_start <= 1'b1;
                    busy      <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mul_done && cnt != '0) begin
                        result <= mul_dout;
                        ack    <= gnt_q;
                        state  <= RESP;
                    end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                        result <= '0;
                        err    <= 1'b1;
                        ack    <= gnt_q;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr <= (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_share_sched.sv
// tb_mul_share_sched: table vectors, directed corner sequences and randomized traffic against a transaction-level model
module tb_mul_share_sched;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] a_bus = '0;
    logic [N*W-1:0] b_bus = '0;
    logic [N-1:0]   ack;
    logic [2*W-1:0] result;
    logic           err;
    logic           busy;
    logic [2:0]     grant_id;
    logic           mul_start;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic [2*W-1:0] mul_dout = '0;
    logic           mul_done = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    mul_share_sched #(.NUM_REQ(N), .W(W), .TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .ack       (ack),
        .result    (result),
        .err       (err),
        .busy      (busy),
        .grant_id  (grant_id),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_dout  (mul_dout),
        .mul_done  (mul_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: done rises 9 cycles after the start cycle and stays high until the next start.
    // mode 0 = normal, 1 = stale done held through the first WAIT cycle, 2 = never done.
    int             mode = 0;
    int             lat = 0;
    logic           pend = 1'b0;
    logic           stale_clr = 1'b0;
    logic [2*W-1:0] prod_q = '0;

    always @(posedge clk) begin
        if (mul_start) begin
            lat       <= 7;
            pend      <= (mode != 2);
            stale_clr <= (mode == 1);
            prod_q    <= 16'(mul_a) * 16'(mul_b);
            if (mode != 1) mul_done <= 1'b0;
        end else begin
            if (stale_clr) begin
                mul_done  <= 1'b0;
                stale_clr <= 1'b0;
            end
            if (pend) begin
                if (lat > 0) lat <= lat - 1;
                else begin
                    mul_done <= 1'b1;
                    mul_dout <= prod_q;
                    pend     <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ack(output int st, output int ac, output int ns);
        st = -1;
        ac = -1;
        ns = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mul_start) begin
                ns++;
                st = cyc;
            end
            if (ack != '0) begin
                ac = cyc;
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL ack_wait: no ack within 200 cycles");
    endtask

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
        logic [N-1:0]   ack;
        logic [2*W-1:0] res;
    } vec_t;

    vec_t tv[5];

    int             st, ac, ns;
    logic [N-1:0]   exp_ack;
    int             m_left, m_ptr, m_id;
    logic [2*W-1:0] m_prod;
    int             ids[5];
    logic [2*W-1:0] res4[5];

    initial begin
        tv[0] = '{4'b0001, 32'h0000_0081, 32'h0000_0013, 4'b0001, 16'h0993};
        tv[1] = '{4'b0010, 32'h0000_1200, 32'h0000_3400, 4'b0010, 16'h03A8};
        tv[2] = '{4'b0100, 32'h00FF_0000, 32'h00FF_0000, 4'b0100, 16'hFE01};
        tv[3] = '{4'b1000, 32'h0000_0000, 32'h7F00_0000, 4'b1000, 16'h0000};
        tv[4] = '{4'b0100, 32'h0080_0000, 32'h0002_0000, 4'b0100, 16'h0100};
        ids  = '{0, 1, 2, 3, 0};
        res4 = '{16'h31B0, 16'h03FC, 16'h0000, 16'hF00F, 16'h31B0};

        do_reset();
        chk("reset_outputs", {ack, err, result, busy, grant_id, mul_start, mul_a, mul_b}, '0);

        // Single-request vectors
        for (int v = 0; v < 5; v++) begin
            req = tv[v].req;
            a_bus = tv[v].a;
            b_bus = tv[v].b;
            wait_ack(st, ac, ns);
            chk($sformatf("vec%0d_ack", v), ack, tv[v].ack);
            chk($sformatf("vec%0d_result", v), result, tv[v].res);
            chk($sformatf("vec%0d_err", v), err, 0);
            chk($sformatf("vec%0d_starts", v), ns, 1);
            chk($sformatf("vec%0d_latency", v), ac - st, 10);
            req = '0;
            @(negedge clk);
            chk($sformatf("vec%0d_busy_after", v), busy, 0);
            chk($sformatf("vec%0d_ack_after", v), ack, 0);
        end

        // All four held high: rotation 0,1,2,3 then 0 again
        do_reset();
        a_bus = {8'hFF, 8'hFF, 8'h0F, 8'hF0};
        b_bus = {8'hF1, 8'h00, 8'h44, 8'h35};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(st, ac, ns);
            if (k == 4) req = '0;
            chk($sformatf("rot%0d_ack", k), ack, 4'b0001 << ids[k]);
            chk($sformatf("rot%0d_grant_id", k), grant_id, ids[k]);
            chk($sformatf("rot%0d_result", k), result, res4[k]);
            chk($sformatf("rot%0d_latency", k), ac - st, 10);
        end
        @(negedge clk);

        // Stale done from the previous operation must not be accepted
        mode = 1;
        do_reset();
        a_bus = 32'h0000_00AB;
        b_bus = 32'h0000_00CD;
        req = 4'b0001;
        wait_ack(st, ac, ns);
        req = '0;
        chk("stale_ack", ack, 4'b0001);
        chk("stale_result", result, 16'h88EF);
        chk("stale_err", err, 0);
        chk("stale_latency", ac - st, 10);
        @(negedge clk);
        mode = 0;

        // Timeout: no done ever arrives
        mode = 2;
        a_bus = 32'h0000_0500;
        b_bus = 32'h0000_0700;
        req = 4'b0010;
        wait_ack(st, ac, ns);
        req = '0;
        chk("to_ack", ack, 4'b0010);
        chk("to_err", err, 1);
        chk("to_result", result, 0);
        chk("to_latency", ac - st, TO + 1);
        @(negedge clk);
        mode = 0;
        chk("to_err_cleared", err, 0);
        req = 4'b0010;
        wait_ack(st, ac, ns);
        req = '0;
        chk("post_to_ack", ack, 4'b0010);
        chk("post_to_result", result, 16'h0023);
        chk("post_to_err", err, 0);
        @(negedge clk);

        // Reset in the middle of WAIT abandons the operation
        a_bus = 32'h0000_1100;
        b_bus = 32'h0000_1100;
        req = 4'b0010;
        for (int i = 0; i < 20 && !mul_start; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", {ack, err, result, busy, grant_id, mul_start, mul_a, mul_b}, '0);
        rst = 1'b0;
        wait_ack(st, ac, ns);
        req = '0;
        chk("midrst_ack", ack, 4'b0010);
        chk("midrst_grant_id", grant_id, 1);
        chk("midrst_result", result, 16'h0121);
        chk("midrst_err", err, 0);
        @(negedge clk);

        // Randomized traffic against a transaction-level model
        do_reset();
        m_left = 0;
        m_ptr = 0;
        m_id = 0;
        m_prod = '0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            exp_ack = (m_left == 1) ? (4'b0001 << m_id) : 4'b0000;
            chk("rnd_busy", busy, m_left > 0);
            chk("rnd_ack", ack, exp_ack);
            if (m_left == 1) begin
                chk("rnd_result", result, m_prod);
                chk("rnd_err", err, 0);
            end
            for (int i = 0; i < N; i++) begin
                if (ack[i]) req[i] = 1'b0;
                else if (m_left > 0 && i == m_id && $urandom_range(0, 7) == 0) begin
                    req[i] = 1'b0;
                    a_bus[i*W +: W] = W'($urandom);
                    b_bus[i*W +: W] = W'($urandom);
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    a_bus[i*W +: W] = W'($urandom);
                    b_bus[i*W +: W] = W'($urandom);
                end
            end
            if (m_left > 0) begin
                if (m_left == 1) m_ptr = (m_id + 1) % N;
                m_left--;
            end else if (req != '0) begin
                for (int k = N - 1; k >= 0; k--)
                    if (req[(m_ptr + k) % N]) m_id = (m_ptr + k) % N;
                m_prod = 16'(a_bus[m_id*W +: W]) * 16'(b_bus[m_id*W +: W]);
                m_left = 11;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
